// File: rtl/cello_func_pkg.sv
// Shared types and constants for the Cello truth-table function blocks.
package cello_func_pkg;

    typedef enum logic {
        EVAL = 1'b0,
        PROG = 1'b1
    } state_e;

    localparam logic [15:0] TT_0x0026 = 16'h0026;
    localparam logic [15:0] TT_ZERO   = 16'h0000;

    function automatic int tt_width(input int n);
        return 32'd1 << n;
    endfunction

endpackage

// File: rtl/cello_settle_cnt.sv
// Stable-input detector and settle down-counter; settled_o marks a cycle where
// the sampled vector has held long enough for the function output to update.
module cello_settle_cnt
    import cello_func_pkg::*;
#(
    parameter int N_IN          = 4,
    parameter int SETTLE_CYCLES = 3,
    parameter int CNT_W         = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            reload_i,
    input  logic [N_IN-1:0] in_vec_i,
    output logic [N_IN-1:0] in_q_o,
    output logic            restart_o,
    output logic            settled_o
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES);

    logic [N_IN-1:0]  in_q;
    logic [CNT_W-1:0] cnt_q;

    // Compare the live vector with the sampled one and flag a completed settle
    always_comb begin
        restart_o = (in_vec_i != in_q);
        if (reload_i) begin
            settled_o = 1'b0;
        end else begin
            settled_o = !restart_o && (cnt_q == {CNT_W{1'b0}});
        end
    end

    // Sample the vector every cycle; any change or a reload restarts the count
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            in_q  <= {N_IN{1'b0}};
            cnt_q <= CNT_INIT;
        end else begin
            in_q <= in_vec_i;
            if (reload_i || restart_o) begin
                cnt_q <= CNT_INIT;
            end else if (cnt_q != {CNT_W{1'b0}}) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end else begin
                cnt_q <= cnt_q;
            end
        end
    end

    assign in_q_o = in_q;

endmodule

// File: rtl/cello_tt_func_seq.sv
// Clocked N-input Boolean function from a reprogrammable truth table, with a
// settle delay that filters input glitches and a serial table-load port.
module cello_tt_func_seq
    import cello_func_pkg::*;
#(
    parameter int                          N_IN          = 4,
    parameter logic [tt_width(N_IN)-1:0]   TABLE_INIT    = TT_0x0026,
    parameter int                          SETTLE_CYCLES = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_IN-1:0] in_vec,
    input  logic            prog_en,
    input  logic            prog_valid,
    input  logic            prog_bit,
    output logic            prog_busy,
    output logic            prog_done,
    output logic            prog_err,
    output logic            out,
    output logic            out_valid,
    output logic            out_change
);

    localparam int TW    = tt_width(N_IN);
    localparam int BCW   = N_IN + 1;
    localparam int CNT_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

    state_e          state_q;
    logic [TW-1:0]   table_q;
    logic [TW-1:0]   shadow_q;
    logic [BCW-1:0]  bit_cnt_q;
    logic            arm_q;
    logic            prog_busy_q;
    logic            prog_done_q;
    logic            prog_err_q;
    logic            out_q;
    logic            out_valid_q;
    logic            out_change_q;

    logic [N_IN-1:0] in_q_s;
    logic            restart_s;
    logic            settled_s;
    logic            reload_s;
    logic            tt_bit_s;

    // Hold the settle counter at its reload value while programming
    always_comb begin
        reload_s = (state_q == PROG);
        tt_bit_s = table_q[in_q_s];
    end

    cello_settle_cnt #(
        .N_IN          (N_IN),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_settle (
        .clk_i     (clk),
        .rst_i     (rst),
        .reload_i  (reload_s),
        .in_vec_i  (in_vec),
        .in_q_o    (in_q_s),
        .restart_o (restart_s),
        .settled_o (settled_s)
    );

    // Mode FSM: evaluation with registered outputs, and serial table programming
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= EVAL;
            table_q      <= TABLE_INIT;
            shadow_q     <= {TW{1'b0}};
            bit_cnt_q    <= {BCW{1'b0}};
            arm_q        <= 1'b1;
            prog_busy_q  <= 1'b0;
            prog_done_q  <= 1'b0;
            prog_err_q   <= 1'b0;
            out_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_change_q <= 1'b0;
        end else begin
            prog_done_q  <= 1'b0;
            prog_err_q   <= 1'b0;
            out_change_q <= 1'b0;
            case (state_q)
                EVAL: begin
                    if (prog_en && arm_q) begin
                        state_q     <= PROG;
                        prog_busy_q <= 1'b1;
                        out_valid_q <= 1'b0;
                        bit_cnt_q   <= {BCW{1'b0}};
                        arm_q       <= 1'b0;
                    end else begin
                        arm_q <= arm_q | ~prog_en;
                        if (restart_s) begin
                            out_valid_q <= 1'b0;
                        end else if (settled_s) begin
                            out_q        <= tt_bit_s;
                            out_valid_q  <= 1'b1;
                            out_change_q <= (tt_bit_s != out_q);
                        end else begin
                            out_valid_q <= out_valid_q;
                        end
                    end
                end
                PROG: begin
                    // A full table commits even if prog_en is still high; re-arm needs prog_en low
                    arm_q <= arm_q | ~prog_en;
                    if (bit_cnt_q == BCW'(TW)) begin
                        table_q     <= shadow_q;
                        prog_done_q <= 1'b1;
                        prog_busy_q <= 1'b0;
                        state_q     <= EVAL;
                    end else if (!prog_en) begin
                        prog_err_q  <= 1'b1;
                        prog_busy_q <= 1'b0;
                        state_q     <= EVAL;
                    end else if (prog_valid) begin
                        shadow_q  <= {shadow_q[TW-2:0], prog_bit};
                        bit_cnt_q <= bit_cnt_q + BCW'(1);
                    end else begin
                        bit_cnt_q <= bit_cnt_q;
                    end
                end
                default: begin
                    state_q     <= EVAL;
                    prog_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign prog_busy  = prog_busy_q;
    assign prog_done  = prog_done_q;
    assign prog_err   = prog_err_q;
    assign out        = out_q;
    assign out_valid  = out_valid_q;
    assign out_change = out_change_q;

endmodule

// File: tb/tb_cello_tt_func_seq.sv
// Self-checking bench for cello_tt_func_seq: vector table plus scoreboard of
// per-cycle expected outputs, and hand-written programming/reset sequences.
module tb_cello_tt_func_seq;

    localparam int S = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_vec;
    logic       prog_en, prog_valid, prog_bit;
    logic       prog_busy, prog_done, prog_err, out, out_valid, out_change;

    typedef struct {
        int   cyc;
        logic out;
        logic valid;
        logic chg;
    } exp_t;

    typedef struct {
        logic [3:0] vec;
        int         hold;
        logic       exp;
    } vec_rec_t;

    exp_t     sb[$];
    vec_rec_t sweep[16];
    int       cyc = 0;
    int       n_tests = 0;
    int       n_fail = 0;
    logic     exp_prev = 1'b0;

    cello_tt_func_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_vec     (in_vec),
        .prog_en    (prog_en),
        .prog_valid (prog_valid),
        .prog_bit   (prog_bit),
        .prog_busy  (prog_busy),
        .prog_done  (prog_done),
        .prog_err   (prog_err),
        .out        (out),
        .out_valid  (out_valid),
        .out_change (out_change)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic act, input logic req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", name, act, req);
        end
    endfunction

    function automatic void push(input int c, input logic o, input logic v, input logic ch);
        exp_t e;
        e.cyc = c; e.out = o; e.valid = v; e.chg = ch;
        sb.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                check($sformatf("out@%0d", cyc), out, sb[i].out);
                check($sformatf("out_valid@%0d", cyc), out_valid, sb[i].valid);
                check($sformatf("out_change@%0d", cyc), out_change, sb[i].chg);
                sb.delete(i);
            end
        end
    endtask

    // Apply a new vector (must differ from the current one) and hold it
    task automatic apply_vec(input logic [3:0] v, input int hold, input logic exp);
        int t;
        in_vec = v;
        t = cyc + 1;
        for (int k = 0; k < hold; k++) begin
            if (k <= S)           push(t + k, exp_prev, 1'b0, 1'b0);
            else if (k == S + 1)  push(t + k, exp, 1'b1, exp != exp_prev);
            else                  push(t + k, exp, 1'b1, 1'b0);
        end
        exp_prev = exp;
        repeat (hold) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] new_tt;
        int          g;
        int          r;
        int          done_cnt;

        sweep = '{
            '{4'd0,  6, 1'b0}, '{4'd1,  6, 1'b1}, '{4'd2,  6, 1'b1}, '{4'd3,  6, 1'b0},
            '{4'd4,  6, 1'b0}, '{4'd5,  6, 1'b1}, '{4'd6,  6, 1'b0}, '{4'd7,  6, 1'b0},
            '{4'd8,  6, 1'b0}, '{4'd9,  6, 1'b0}, '{4'd10, 6, 1'b0}, '{4'd11, 6, 1'b0},
            '{4'd12, 6, 1'b0}, '{4'd13, 6, 1'b0}, '{4'd14, 6, 1'b0}, '{4'd15, 6, 1'b0}
        };

        // Reset defaults
        rst = 1'b1; in_vec = 4'b0001; prog_en = 1'b0; prog_valid = 1'b0; prog_bit = 1'b0;
        repeat (3) tick();
        check("rst_out", out, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", prog_busy, 1'b0);
        check("rst_done", prog_done, 1'b0);
        check("rst_err", prog_err, 1'b0);
        check("rst_change", out_change, 1'b0);
        rst = 1'b0;
        exp_prev = 1'b0;
        in_vec = 4'b0000;
        apply_vec(4'b0001, 6, 1'b1);

        // Default table sweep
        for (int i = 0; i < 16; i++) apply_vec(sweep[i].vec, sweep[i].hold, sweep[i].exp);

        // Glitch filter: 2-cycle pulse must not reach out
        apply_vec(4'b0000, 6, 1'b0);
        in_vec = 4'b0001;
        g = cyc + 1;
        push(g, 1'b0, 1'b0, 1'b0);
        push(g + 1, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        in_vec = 4'b0000;
        for (int k = 2; k <= S + 2; k++) push(g + k, 1'b0, 1'b0, 1'b0);
        push(g + S + 3, 1'b0, 1'b1, 1'b0);
        push(g + S + 4, 1'b0, 1'b1, 1'b0);
        repeat (S + 3) tick();

        // Abort after 9 bits leaves the default table in place
        apply_vec(4'b0010, 6, 1'b1);
        prog_en = 1'b1;
        tick();
        check("abort_enter_busy", prog_busy, 1'b1);
        check("abort_enter_valid", out_valid, 1'b0);
        check("abort_enter_out_hold", out, 1'b1);
        for (int b = 0; b < 9; b++) begin
            prog_valid = 1'b1; prog_bit = 1'b0;
            tick();
        end
        check("abort_busy_mid", prog_busy, 1'b1);
        prog_valid = 1'b0; prog_en = 1'b0;
        tick();
        r = cyc;
        check("abort_err_pulse", prog_err, 1'b1);
        check("abort_no_done", prog_done, 1'b0);
        check("abort_busy_clr", prog_busy, 1'b0);
        for (int k = 1; k <= S; k++) push(r + k, 1'b1, 1'b0, 1'b0);
        push(r + S + 1, 1'b1, 1'b1, 1'b0);
        tick();
        check("abort_err_single", prog_err, 1'b0);
        repeat (S) tick();
        apply_vec(4'b0101, 6, 1'b1);
        apply_vec(4'b0100, 6, 1'b0);

        // Program 16'h8000 with prog_valid gaps
        new_tt = 16'h8000;
        done_cnt = 0;
        prog_en = 1'b1;
        tick();
        check("prog_enter_busy", prog_busy, 1'b1);
        for (int i = 15; i >= 0; i--) begin
            prog_valid = 1'b1; prog_bit = new_tt[i];
            tick();
            if (prog_done) done_cnt++;
            if (i % 4 == 1) begin
                prog_valid = 1'b0;
                tick();
                if (prog_done) done_cnt++;
            end
        end
        check("prog_busy_last_bit", prog_busy, 1'b1);
        check("prog_done_not_early", prog_done, 1'b0);
        prog_valid = 1'b1; prog_bit = 1'b1;
        tick();
        if (prog_done) done_cnt++;
        check("prog_done_pulse", prog_done, 1'b1);
        check("prog_busy_after_commit", prog_busy, 1'b0);
        for (int k = 0; k < 3; k++) begin
            prog_valid = k[0];
            tick();
            if (prog_done) done_cnt++;
            check("prog_no_rearm", prog_busy, 1'b0);
        end
        check("prog_done_once", done_cnt == 1, 1'b1);
        prog_en = 1'b0; prog_valid = 1'b0;
        apply_vec(4'b1111, 6, 1'b1);
        apply_vec(4'b0001, 6, 1'b0);
        apply_vec(4'b1110, 6, 1'b0);

        // Async reset during programming restores the default table
        apply_vec(4'b1111, 6, 1'b1);
        prog_en = 1'b1;
        tick();
        check("rstprog_busy", prog_busy, 1'b1);
        check("rstprog_out_hold", out, 1'b1);
        for (int b = 0; b < 5; b++) begin
            prog_valid = 1'b1; prog_bit = 1'b1;
            tick();
        end
        #3;
        rst = 1'b1;
        #1;
        check("arst_out", out, 1'b0);
        check("arst_busy", prog_busy, 1'b0);
        check("arst_valid", out_valid, 1'b0);
        check("arst_done", prog_done, 1'b0);
        check("arst_err", prog_err, 1'b0);
        prog_en = 1'b0; prog_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        exp_prev = 1'b0;
        apply_vec(4'b0001, 6, 1'b1);
        apply_vec(4'b1111, 6, 1'b0);

        check("sb_drained", sb.size() == 0, 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
